// File: rtl/mb_wr_seq_pkg.sv
// MBOX write-data sequencer shared types.
// Word type, state encoding and default ack timeout.
package mb_wr_seq_pkg;
  localparam int MB_WR_WIDTH = 36;
  localparam int MB_WR_ACK_TIMEOUT = 64;

  typedef logic [0:MB_WR_WIDTH-1] tWord;

  typedef enum logic {
    IDLE,
    XFER
  } tMbWrState;

  function automatic logic odd_par(tWord w);
    return ~^w;
  endfunction
endpackage

// File: rtl/mb_ack_timer.sv
// Memory acknowledge watchdog.
// Saturating count of VALID cycles without ACKN.
module mb_ack_timer
  import mb_wr_seq_pkg::*;
#(
  parameter int ACK_TIMEOUT = MB_WR_ACK_TIMEOUT
) (
  input  logic clk,
  input  logic RESET,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  logic [TW-1:0] cnt;

  // Count stalled cycles; hold at the limit instead of wrapping.
  always_ff @(posedge clk) begin
    if (RESET || clear) begin
      cnt <= '0;
    end else if (run && cnt != TW'(ACK_TIMEOUT)) begin
      cnt <= cnt + TW'(1);
    end
  end

  // The stall that lands on the limit is the expiring one.
  assign expired = run && (cnt >= TW'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/mb_wr_seq.sv
// MBOX memory write-data sequencer.
// Sends masked MB words in quadword wrap order with odd parity.
module mb_wr_seq
  import mb_wr_seq_pkg::*;
#(
  parameter int WIDTH       = 36,
  parameter int NWORDS      = 4,
  parameter int ACK_TIMEOUT = MB_WR_ACK_TIMEOUT
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             START,
  input  logic [0:1]       START_WORD,
  input  logic [0:3]       WORD_REQ,
  input  logic [0:WIDTH-1] MB0_IN,
  input  logic [0:WIDTH-1] MB1_IN,
  input  logic [0:WIDTH-1] MB2_IN,
  input  logic [0:WIDTH-1] MB3_IN,
  input  logic             MEM_ACKN,
  output logic [0:WIDTH-1] MEM_DATA_OUT,
  output logic             MEM_PAR_OUT,
  output logic             MEM_DATA_VALID,
  output logic [0:1]       MEM_WORD_NUM,
  output logic             BUSY,
  output logic             DONE,
  output logic             NXM
);

  tMbWrState state, state_n;
  tWord snap [0:3];
  tWord snap_n [0:3];
  tWord in_w [0:3];
  tWord data, data_n;
  logic [0:3] mask, mask_n;
  logic [1:0] cur, cur_n, nxt;
  logic [2:0] visits, visits_n;
  logic valid, valid_n;
  logic par, par_n;
  logic done, done_n;
  logic nxm, nxm_n;
  logic start_ok, xfer, run, expired;

  assign in_w[0] = MB0_IN;
  assign in_w[1] = MB1_IN;
  assign in_w[2] = MB2_IN;
  assign in_w[3] = MB3_IN;

  assign start_ok = (state == IDLE) && START;
  assign xfer     = valid && MEM_ACKN;
  assign run      = valid && !MEM_ACKN;
  assign nxt      = cur + 2'd1;

  mb_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .RESET   (RESET),
    .run     (run),
    .clear   (xfer || start_ok),
    .expired (expired)
  );

  // State, snapshot and registered output bus.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state  <= IDLE;
      snap   <= '{default: '0};
      mask   <= '0;
      cur    <= '0;
      visits <= '0;
      valid  <= 1'b0;
      data   <= '0;
      par    <= 1'b0;
      done   <= 1'b0;
      nxm    <= 1'b0;
    end else begin
      state  <= state_n;
      snap   <= snap_n;
      mask   <= mask_n;
      cur    <= cur_n;
      visits <= visits_n;
      valid  <= valid_n;
      data   <= data_n;
      par    <= par_n;
      done   <= done_n;
      nxm    <= nxm_n;
    end
  end

  // Next state: VALID always mirrors mask[cur] while in XFER,
  // so a zero VALID cycle is exactly one skip.
  always_comb begin
    state_n  = state;
    snap_n   = snap;
    mask_n   = mask;
    cur_n    = cur;
    visits_n = visits;
    valid_n  = valid;
    data_n   = data;
    par_n    = par;
    done_n   = 1'b0;
    nxm_n    = nxm;
    unique case (state)
      IDLE: begin
        if (START) begin
          state_n  = XFER;
          snap_n   = in_w;
          mask_n   = WORD_REQ;
          cur_n    = START_WORD;
          visits_n = '0;
          nxm_n    = 1'b0;
          valid_n  = WORD_REQ[START_WORD];
          data_n   = WORD_REQ[START_WORD] ? in_w[START_WORD] : '0;
          par_n    = WORD_REQ[START_WORD] &&
                     odd_par(in_w[START_WORD]);
        end
      end
      XFER: begin
        if (run) begin
          if (expired) begin
            state_n = IDLE;
            nxm_n   = 1'b1;
            done_n  = 1'b1;
            valid_n = 1'b0;
            data_n  = '0;
            par_n   = 1'b0;
          end
        end else begin
          if (xfer) mask_n[cur] = 1'b0;
          cur_n    = nxt;
          visits_n = visits + 3'd1;
          if (visits == 3'(NWORDS - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
            valid_n = 1'b0;
            data_n  = '0;
            par_n   = 1'b0;
          end else begin
            valid_n = mask[nxt];
            data_n  = mask[nxt] ? snap[nxt] : '0;
            par_n   = mask[nxt] && odd_par(snap[nxt]);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign MEM_DATA_OUT   = data;
  assign MEM_PAR_OUT    = par;
  assign MEM_DATA_VALID = valid;
  assign MEM_WORD_NUM   = cur;
  assign BUSY           = (state == XFER);
  assign DONE           = done;
  assign NXM            = nxm;

endmodule

// File: tb/tb_mb_wr_seq.sv
// Directed bench for mb_wr_seq.
// Hand-computed vectors, one checking task.
module tb_mb_wr_seq;

  logic        clk = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [0:1]  START_WORD = '0;
  logic [0:3]  WORD_REQ = '0;
  logic [0:35] mb0 = '0, mb1 = '0, mb2 = '0, mb3 = '0;
  logic        MEM_ACKN = 1'b0;
  logic [0:35] MEM_DATA_OUT;
  logic        MEM_PAR_OUT;
  logic        MEM_DATA_VALID;
  logic [0:1]  MEM_WORD_NUM;
  logic        BUSY;
  logic        DONE;
  logic        NXM;

  int n_chk = 0;
  int n_pass = 0;

  mb_wr_seq dut (
    .clk            (clk),
    .RESET          (RESET),
    .START          (START),
    .START_WORD     (START_WORD),
    .WORD_REQ       (WORD_REQ),
    .MB0_IN         (mb0),
    .MB1_IN         (mb1),
    .MB2_IN         (mb2),
    .MB3_IN         (mb3),
    .MEM_ACKN       (MEM_ACKN),
    .MEM_DATA_OUT   (MEM_DATA_OUT),
    .MEM_PAR_OUT    (MEM_PAR_OUT),
    .MEM_DATA_VALID (MEM_DATA_VALID),
    .MEM_WORD_NUM   (MEM_WORD_NUM),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .NXM            (NXM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] sw, input logic [3:0] req);
    START_WORD = sw;
    WORD_REQ   = req;
    START      = 1'b1;
    tick();
    START      = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [1:0] num,
                          input logic [35:0] d, input logic p);
    chk({tag, "_valid"}, MEM_DATA_VALID, 1'b1);
    chk({tag, "_num"},   MEM_WORD_NUM, num);
    chk({tag, "_data"},  MEM_DATA_OUT, d);
    chk({tag, "_par"},   MEM_PAR_OUT, p);
    chk({tag, "_done"},  DONE, 1'b0);
  endtask

  task automatic chk_idle_done(input string tag, input logic nx);
    chk({tag, "_valid"}, MEM_DATA_VALID, 1'b0);
    chk({tag, "_data"},  MEM_DATA_OUT, 36'h0);
    chk({tag, "_done"},  DONE, 1'b1);
    chk({tag, "_busy"},  BUSY, 1'b0);
    chk({tag, "_nxm"},   NXM, nx);
  endtask

  logic [35:0] ed [4];
  logic [1:0]  en [4];
  logic        ep [4];
  int          vcnt;

  initial begin
    // Reset state
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    chk("rst_valid", MEM_DATA_VALID, 1'b0);
    chk("rst_busy",  BUSY, 1'b0);
    chk("rst_done",  DONE, 1'b0);
    chk("rst_nxm",   NXM, 1'b0);
    chk("rst_data",  MEM_DATA_OUT, 36'h0);
    chk("rst_par",   MEM_PAR_OUT, 1'b0);
    chk("rst_num",   MEM_WORD_NUM, 2'd0);

    // Full quad from word 0, continuous ack
    mb0 = 36'd0; mb1 = 36'd1; mb2 = 36'd2; mb3 = 36'd3;
    MEM_ACKN = 1'b1;
    go(2'd0, 4'b1111);
    chk("q0_busy", BUSY, 1'b1);
    ed = '{36'd0, 36'd1, 36'd2, 36'd3};
    ep = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      chk_word("q0", 2'(k), ed[k], ep[k]);
      tick();
    end
    chk_idle_done("q0_end", 1'b0);
    tick();
    chk("q0_done_pulse", DONE, 1'b0);

    // Wrap order from word 2, inputs changed after START
    mb0 = 36'h0_0000_0001;
    mb1 = 36'h8_0000_0001;
    mb2 = 36'h0_0000_0007;
    mb3 = 36'hF_0000_0000;
    go(2'd2, 4'b1111);
    mb0 = 36'hF_FFFF_FFFF; mb1 = 36'hA_AAAA_AAAA;
    mb2 = 36'h5_5555_5555; mb3 = 36'h0_0000_00FE;
    ed = '{36'h0_0000_0007, 36'hF_0000_0000,
           36'h0_0000_0001, 36'h8_0000_0001};
    en = '{2'd2, 2'd3, 2'd0, 2'd1};
    ep = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      chk_word("wrap", en[k], ed[k], ep[k]);
      tick();
    end
    chk_idle_done("wrap_end", 1'b0);
    tick();

    // Sparse mask 1010 from word 1: skip, MB2, skip, MB0
    mb0 = 36'h0_0000_0003; mb2 = 36'h0_0000_0001;
    go(2'd1, 4'b1010);
    chk("sp_skip1", MEM_DATA_VALID, 1'b0);
    chk("sp_skip1_data", MEM_DATA_OUT, 36'h0);
    tick();
    chk_word("sp_w2", 2'd2, 36'h0_0000_0001, 1'b0);
    tick();
    chk("sp_skip3", MEM_DATA_VALID, 1'b0);
    tick();
    chk_word("sp_w0", 2'd0, 36'h0_0000_0003, 1'b1);
    tick();
    chk_idle_done("sp_end", 1'b0);
    tick();

    // Empty mask: four skips, DONE on fifth cycle
    go(2'd3, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      chk("empty_valid", MEM_DATA_VALID, 1'b0);
      chk("empty_busy", BUSY, 1'b1);
      chk("empty_done", DONE, 1'b0);
      tick();
    end
    chk_idle_done("empty_end", 1'b0);
    tick();

    // Ack after 10 cycles per word, stray START mid-transfer
    mb0 = 36'h1_0000_0000; mb1 = 36'h0_0000_0011;
    mb2 = 36'h0_0000_0100; mb3 = 36'h7_0000_0000;
    MEM_ACKN = 1'b0;
    go(2'd0, 4'b1111);
    ed = '{36'h1_0000_0000, 36'h0_0000_0011,
           36'h0_0000_0100, 36'h7_0000_0000};
    ep = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 10; j++) begin
        chk_word("slow", 2'(k), ed[k], ep[k]);
        chk("slow_nxm", NXM, 1'b0);
        MEM_ACKN = (j == 9);
        START = (k == 1 && j == 3);
        WORD_REQ = 4'b0000;
        tick();
      end
    end
    START = 1'b0;
    MEM_ACKN = 1'b0;
    chk_idle_done("slow_end", 1'b0);
    tick();
    chk("slow_after", DONE, 1'b0);

    // No ack: timeout after 64 VALID cycles
    go(2'd0, 4'b1000);
    vcnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (!MEM_DATA_VALID) break;
      vcnt++;
      tick();
    end
    chk("to_valid_cycles", vcnt, 64);
    chk_idle_done("to_end", 1'b1);
    tick();
    chk("to_done_pulse", DONE, 1'b0);
    chk("to_nxm_sticky", NXM, 1'b1);
    go(2'd0, 4'b0000);
    chk("to_nxm_clear", NXM, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    chk_idle_done("to_clr_end", 1'b0);
    tick();

    // Ack on the 64th stalled cycle wins
    go(2'd0, 4'b1000);
    for (int i = 0; i < 63; i++) tick();
    chk("late_valid64", MEM_DATA_VALID, 1'b1);
    MEM_ACKN = 1'b1;
    tick();
    MEM_ACKN = 1'b0;
    chk("late_valid", MEM_DATA_VALID, 1'b0);
    chk("late_nxm", NXM, 1'b0);
    chk("late_busy", BUSY, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    chk_idle_done("late_end", 1'b0);
    tick();

    // Reset during word 2, then a normal quad
    mb0 = 36'h0_0000_0001; mb1 = 36'h0_0000_0002;
    mb2 = 36'h0_0000_0004; mb3 = 36'h0_0000_0008;
    MEM_ACKN = 1'b1;
    go(2'd1, 4'b1111);
    chk_word("rm_w1", 2'd1, 36'h2, 1'b0);
    tick();
    chk_word("rm_w2", 2'd2, 36'h4, 1'b0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rm_valid", MEM_DATA_VALID, 1'b0);
    chk("rm_busy", BUSY, 1'b0);
    chk("rm_done", DONE, 1'b0);
    chk("rm_data", MEM_DATA_OUT, 36'h0);
    chk("rm_par", MEM_PAR_OUT, 1'b0);
    chk("rm_num", MEM_WORD_NUM, 2'd0);
    tick();
    chk("rm_done2", DONE, 1'b0);
    go(2'd3, 4'b1111);
    ed = '{36'h8, 36'h1, 36'h2, 36'h4};
    en = '{2'd3, 2'd0, 2'd1, 2'd2};
    for (int k = 0; k < 4; k++) begin
      chk_word("rs", en[k], ed[k], 1'b0);
      tick();
    end
    chk_idle_done("rs_end", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
